seq_wr: RTL and testbench

Frame serializer that sits directly upstream of the `seq_rd` byte-frame receiver and the `seq_detect` pattern detector, and drives their shared `data_in` line. On a start request it latches four data bytes and emits one 48-bit frame MSB-first: header, four data bytes, then an 8-bit additive checksum. It replaces hand-written bit stimulus and is the on-chip source for loopback tests of the receive path.

---
 rtl/seq_wr.sv | 119 +++++++++++
 tb/tb_seq_wr.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_wr.sv
// Frame serializer: HEADER, four latched payload bytes, then an 8-bit additive checksum, all MSB-first.
// Latency: on the edge that accepts start, data_out shows HEADER[7]; each bit then holds for CLK_PER_BIT clocks.
// Backpressure: start is taken only while ready=1; a start seen while ready=0 is dropped, with no queuing.
module seq_wr #(
  parameter logic [7:0]  HEADER      = 8'hE8,
  parameter int unsigned CLK_PER_BIT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] in_data0,
  input  logic [7:0] in_data1,
  input  logic [7:0] in_data2,
  input  logic [7:0] in_data3,
  output logic       data_out,
  output logic       ready,
  output logic       busy,
  output logic       done
);

  localparam int unsigned   PW   = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam logic [PW-1:0] PMAX = PW'(CLK_PER_BIT - 1);

  typedef enum logic {IDLE, SEND} state_t;

  typedef struct packed {
    logic [7:0] d0;
    logic [7:0] d1;
    logic [7:0] d2;
    logic [7:0] d3;
    logic [7:0] chk;
  } payload_t;

  state_t        state_q, state_d;
  logic [2:0]    byte_q, byte_d;
  logic [2:0]    bit_q, bit_d;
  logic [PW-1:0] pre_q, pre_d;
  payload_t      pay_q, pay_d;
  logic [7:0]    chk_new;
  logic [7:0]    cur_byte;
  logic          dout_d, done_d, busy_d;
  logic          last_clk, accept;

  // Carries beyond bit 7 are dropped by the truncating cast.
  assign chk_new  = 8'(10'(in_data0) + 10'(in_data1) + 10'(in_data2) + 10'(in_data3));

  assign last_clk = (state_q == SEND) && (byte_q == 3'd5) && (bit_q == 3'd0) && (pre_q == PMAX);
  assign ready    = (state_q == IDLE) || last_clk;
  assign accept   = start && ready;

  always_comb begin
    state_d = state_q;
    byte_d  = byte_q;
    bit_d   = bit_q;
    pre_d   = pre_q;
    pay_d   = pay_q;
    if (accept) begin
      state_d = SEND;
      byte_d  = 3'd0;
      bit_d   = 3'd7;
      pre_d   = '0;
      pay_d   = '{d0: in_data0, d1: in_data1, d2: in_data2, d3: in_data3, chk: chk_new};
    end else if (state_q == SEND) begin
      if (last_clk) begin
        state_d = IDLE;
        byte_d  = 3'd0;
        bit_d   = 3'd7;
        pre_d   = '0;
      end else if (pre_q == PMAX) begin
        pre_d = '0;
        bit_d = bit_q - 3'd1;
        if (bit_q == 3'd0) begin
          byte_d = byte_q + 3'd1;
        end
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end
  end

  // Outputs are registered, so they are derived from next-state values.
  always_comb begin
    cur_byte = HEADER;
    case (byte_d)
      3'd1:    cur_byte = pay_d.d0;
      3'd2:    cur_byte = pay_d.d1;
      3'd3:    cur_byte = pay_d.d2;
      3'd4:    cur_byte = pay_d.d3;
      3'd5:    cur_byte = pay_d.chk;
      default: cur_byte = HEADER;
    endcase
    busy_d = (state_d == SEND);
    dout_d = busy_d ? cur_byte[bit_d] : 1'b1;
    done_d = busy_d && (byte_d == 3'd5) && (bit_d == 3'd0) && (pre_d == PMAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      byte_q   <= 3'd0;
      bit_q    <= 3'd0;
      pre_q    <= '0;
      pay_q    <= '0;
      data_out <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      byte_q   <= byte_d;
      bit_q    <= bit_d;
      pre_q    <= pre_d;
      pay_q    <= pay_d;
      data_out <= dout_d;
      busy     <= busy_d;
      done     <= done_d;
    end
  end

endmodule

// File: tb/tb_seq_wr.sv
// Bench for seq_wr: instance 0 runs with one clock per bit, instance 1 with four clocks per bit.
// A reference model queues the frames it expects, and a monitor rebuilds each frame from the serial line.
module tb_seq_wr;

  localparam logic [7:0] HDR = 8'hE8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start    [2];
  logic [7:0] din      [2][4];
  logic       data_out [2];
  logic       ready    [2];
  logic       busy     [2];
  logic       done     [2];

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [47:0] mk_frame(input logic [7:0] a, input logic [7:0] b,
                                           input logic [7:0] c, input logic [7:0] e);
    int s;
    s = int'(a) + int'(b) + int'(c) + int'(e);
    return {HDR, a, b, c, e, 8'(s % 256)};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int CPB  = (g == 0) ? 1 : 4;
    localparam int LAST = 48 * CPB - 1;

    logic [47:0] exp_q[$];
    logic [47:0] cap;
    logic [47:0] want;
    int          cnt = 0;
    int          m_pos = 0;
    bit          m_act = 0;
    bit          exp_rdy;

    seq_wr #(.HEADER(HDR), .CLK_PER_BIT(CPB)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start[g]),
      .in_data0 (din[g][0]),
      .in_data1 (din[g][1]),
      .in_data2 (din[g][2]),
      .in_data3 (din[g][3]),
      .data_out (data_out[g]),
      .ready    (ready[g]),
      .busy     (busy[g]),
      .done     (done[g])
    );

    // Reference model: frame-level timing and acceptance; pushes the frames it expects.
    always @(negedge clk) begin
      if (!rst_n) begin
        m_act = 0;
        m_pos = 0;
      end else begin
        exp_rdy = !m_act || (m_pos == LAST);
        check($sformatf("i%0d_ready", g), ready[g], exp_rdy);
        check($sformatf("i%0d_busy", g), busy[g], m_act);
        if (m_act) begin
          if (m_pos == LAST) m_act = 0;
          else               m_pos++;
        end
        if (exp_rdy && start[g]) begin
          exp_q.push_back(mk_frame(din[g][0], din[g][1], din[g][2], din[g][3]));
          m_act = 1;
          m_pos = 0;
        end
      end
    end

    // Monitor: samples the line, checks bit hold times, and compares each whole frame at done.
    always @(negedge clk) begin
      if (!rst_n) begin
        cnt = 0;
        exp_q.delete();
      end else if (busy[g]) begin
        if (cnt % CPB == 0) cap = {cap[46:0], data_out[g]};
        else check($sformatf("i%0d_bit_hold", g), data_out[g], cap[0]);
        cnt++;
        if (done[g]) begin
          check($sformatf("i%0d_frame_len", g), cnt, LAST + 1);
          check($sformatf("i%0d_frame_expected", g), exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            check($sformatf("i%0d_frame_bits", g), cap, want);
          end
          cnt = 0;
        end else if (cnt > LAST) begin
          check($sformatf("i%0d_frame_overrun", g), cnt, LAST + 1);
          cnt = 0;
        end
      end else begin
        check($sformatf("i%0d_idle_line", g), data_out[g], 1);
        check($sformatf("i%0d_idle_done", g), done[g], 0);
        check($sformatf("i%0d_busy_dropped_at", g), cnt, 0);
        cnt = 0;
      end
    end
  end

  task automatic reset_vals(input int g, input string tag);
    check($sformatf("%s_i%0d_data_out", tag, g), data_out[g], 1);
    check($sformatf("%s_i%0d_ready", tag, g), ready[g], 1);
    check($sformatf("%s_i%0d_busy", tag, g), busy[g], 0);
    check($sformatf("%s_i%0d_done", tag, g), done[g], 0);
  endtask

  // Called #1 after a rising edge; leaves the stimulus #1 after the accepting edge.
  task automatic fire(input int g, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] c, input logic [7:0] e);
    din[g][0] = a; din[g][1] = b; din[g][2] = c; din[g][3] = e;
    start[g] = 1'b1;
    @(posedge clk); #1;
    start[g] = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rand_run(input int g, input int n);
    for (int i = 0; i < n; i++) begin
      start[g] = ($urandom_range(0, 5) == 0);
      for (int k = 0; k < 4; k++) din[g][k] = 8'($urandom);
      @(posedge clk); #1;
    end
    start[g] = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    for (int g = 0; g < 2; g++) begin
      start[g] = 1'b0;
      for (int k = 0; k < 4; k++) din[g][k] = 8'h00;
    end
    #12;
    reset_vals(0, "por");
    reset_vals(1, "por");
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_cyc(2);

    // Basic frame.
    fire(0, 8'hF0, 8'h0F, 8'hFF, 8'hAA);
    wait_cyc(52);

    // Back-to-back: start held across three frames, data changed after each acceptance.
    din[0][0] = 8'hAA; din[0][1] = 8'hAA; din[0][2] = 8'hAA; din[0][3] = 8'hA8;
    start[0] = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) din[0][k] = 8'h00;
    wait_cyc(48);
    din[0][0] = 8'h12; din[0][1] = 8'h34; din[0][2] = 8'h56; din[0][3] = 8'h78;
    wait_cyc(48);
    start[0] = 1'b0;
    wait_cyc(52);

    // Data stability: inputs cleared one clock after acceptance.
    fire(0, 8'hC3, 8'h5A, 8'h81, 8'h7E);
    for (int k = 0; k < 4; k++) din[0][k] = 8'h00;
    wait_cyc(52);

    // Ignored start mid-frame.
    fire(0, 8'h11, 8'h22, 8'h33, 8'h44);
    wait_cyc(19);
    start[0] = 1'b1;
    din[0][0] = 8'hFF;
    wait_cyc(1);
    start[0] = 1'b0;
    wait_cyc(32);

    // Asynchronous reset in the middle of a frame.
    fire(0, 8'h00, 8'h00, 8'h00, 8'h00);
    wait_cyc(29);
    #2 rst_n = 1'b0;
    #1;
    reset_vals(0, "midrst");
    wait_cyc(2);
    rst_n = 1'b1;
    wait_cyc(1);
    fire(0, 8'h9C, 8'h01, 8'hFE, 8'h40);
    wait_cyc(52);

    rand_run(0, 700);
    wait_cyc(52);

    // Prescaled instance.
    fire(1, 8'h01, 8'h02, 8'h03, 8'h04);
    wait_cyc(200);
    rand_run(1, 1200);
    wait_cyc(200);

    check("i0_leftover_frames", g_dut[0].exp_q.size(), 0);
    check("i1_leftover_frames", g_dut[1].exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
